// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-store queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   STORE_BUFFER_DEPTH - default number of queue entries
//   sb_entry_t         - one pending store {addr, data, is_byte, pc}
//   word_addr()        - word-granular address used for load matching
package store_buffer_pkg;

    localparam int STORE_BUFFER_DEPTH = 4;

    // is_byte: 1 = sb (data[7:0] significant), 0 = sw
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        is_byte;
        logic [31:0] pc;
    } sb_entry_t;

    // Loads and stores alias whenever they touch the same 32-bit word.
    function automatic logic [29:0] word_addr(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/store_buffer_sb_match.sv
// Youngest-match search over the pending stores for one load address.
// Latency: purely combinational.
// Backpressure: none; the caller turns a byte-store hit into a stall.
//
// Ports:
//   ent_word  - word address of every slot
//   ent_byte  - byte-store flag of every slot
//   valid     - slot holds a pending store
//   tail      - next write slot; tail-1 is the youngest entry
//   ld_word   - word address of the load
//   hit_valid - some valid slot matches
//   hit_idx   - slot of the youngest match
//   hit_byte  - youngest match is a byte store
module sb_match #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic [29:0]      ent_word [DEPTH],
    input  logic [DEPTH-1:0] ent_byte,
    input  logic [DEPTH-1:0] valid,
    input  logic [PW-1:0]    tail,
    input  logic [29:0]      ld_word,
    output logic             hit_valid,
    output logic [PW-1:0]    hit_idx,
    output logic             hit_byte
);

    logic [PW-1:0] idx;

    // Walk from the oldest possible slot (tail-DEPTH) to the youngest
    // (tail-1); a later match overrides an earlier one, so the final
    // result is the youngest. Modulo arithmetic on idx handles the wrap.
    always_comb begin
        hit_valid = 1'b0;
        hit_idx   = '0;
        hit_byte  = 1'b0;
        idx       = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PW'(k);
            if (valid[idx] && (ent_word[idx] == ld_word)) begin
                hit_valid = 1'b1;
                hit_idx   = idx;
                hit_byte  = ent_byte[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-store queue between MEM and data memory, with load conflict check.
// Latency: a store accepted at edge N can write memory at edge N+1; one push and one pop per cycle.
// Backpressure: st_ready drops when all DEPTH slots are occupied; drain_en gates the memory write.
//
// Build option: define STORE_BUFFER_FWD_EN to forward full-word hits to
// loads (youngest match wins, byte-store hit stalls). Without it every
// address hit stalls the load and nothing is forwarded.
//
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   st_valid/st_ready, st_addr, st_data, st_byte, st_pc - store push
//   ld_valid, ld_addr                  - load to check against pending stores
//   ld_hit, ld_data, ld_stall          - forward / stall result for the load
//   drain_en                           - allow head to be written this cycle
//   dm_we, dm_addr, dm_wd, dm_bh, dm_pc - data-memory write port (head entry)
//   empty                              - no pending stores (syscall/eret fence)
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = STORE_BUFFER_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic        st_byte,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        ld_stall,
    input  logic        drain_en,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic        dm_bh,
    output logic [31:0] dm_pc,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

    sb_entry_t        entries [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;
    logic [DEPTH-1:0] valid;
    logic             push;
    logic             pop;
    logic [29:0]      ld_word;

    assign st_ready = (count < FULL_COUNT);
    assign empty    = (count == '0);
    // Reset discards the queue, so the head must not reach memory on that edge.
    assign dm_we    = !empty && drain_en && !reset;
    assign push     = st_valid && st_ready;
    assign pop      = dm_we;

    // Stale head is presented when empty; dm_we qualifies it.
    assign dm_addr  = entries[head].addr;
    assign dm_wd    = entries[head].data;
    assign dm_bh    = entries[head].is_byte;
    assign dm_pc    = entries[head].pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage has no reset; validity comes from head/count only.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            entries[tail] <= '{addr: st_addr, data: st_data, is_byte: st_byte, pc: st_pc};
        end
    end

    // Slot i is pending when its distance from head is below count.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, PW'(i) - head} < count);
        end
    end

    assign ld_word = word_addr(ld_addr);

`ifdef STORE_BUFFER_FWD_EN
    logic [29:0]      ent_word [DEPTH];
    logic [DEPTH-1:0] ent_byte;
    logic             hit_valid;
    logic [PW-1:0]    hit_idx;
    logic             hit_byte;

    always_comb begin
        ent_byte = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_word[i] = word_addr(entries[i].addr);
            ent_byte[i] = entries[i].is_byte;
        end
    end

    sb_match #(
        .DEPTH(DEPTH)
    ) u_sb_match (
        .ent_word  (ent_word),
        .ent_byte  (ent_byte),
        .valid     (valid),
        .tail      (tail),
        .ld_word   (ld_word),
        .hit_valid (hit_valid),
        .hit_idx   (hit_idx),
        .hit_byte  (hit_byte)
    );

    // A byte store only covers part of the word, so the load must wait
    // until that entry has reached memory.
    assign ld_hit   = ld_valid && hit_valid && !hit_byte;
    assign ld_stall = ld_valid && hit_valid && hit_byte;
    assign ld_data  = ld_hit ? entries[hit_idx].data : '0;
`else
    logic any_match;

    always_comb begin
        any_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (word_addr(entries[i].addr) == ld_word)) begin
                any_match = 1'b1;
            end
        end
    end

    assign ld_hit   = 1'b0;
    assign ld_data  = '0;
    assign ld_stall = ld_valid && any_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed vector bench for store_buffer (DEPTH=4).
// Each vector drives one cycle of inputs and lists the outputs expected
// during that cycle, before the rising edge that commits it.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_byte;
    logic [31:0] st_pc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        drain_en;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic        dm_bh;
    logic [31:0] dm_pc;
    logic        empty;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_byte  (st_byte),
        .st_pc    (st_pc),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_hit   (ld_hit),
        .ld_data  (ld_data),
        .ld_stall (ld_stall),
        .drain_en (drain_en),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wd    (dm_wd),
        .dm_bh    (dm_bh),
        .dm_pc    (dm_pc),
        .empty    (empty)
    );

    // e_stall_fwd / e_stall_nf: expected ld_stall with and without forwarding.
    // e_hit / e_ld only apply to the forwarding build; otherwise both are 0.
    typedef struct {
        logic        rst;
        logic        st_v;
        logic [31:0] st_a;
        logic [31:0] st_d;
        logic        st_b;
        logic [31:0] st_p;
        logic        ld_v;
        logic [31:0] ld_a;
        logic        drn;
        logic        e_rdy;
        logic        e_empty;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_bh;
        logic [31:0] e_pc;
        logic        e_hit;
        logic [31:0] e_ld;
        logic        e_stall_fwd;
        logic        e_stall_nf;
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    function automatic vec_t mk(
        input logic rst, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
        input logic sb, input logic [31:0] sp, input logic lv, input logic [31:0] la,
        input logic drn, input logic rdy, input logic emp, input logic we,
        input logic [31:0] a, input logic [31:0] wd, input logic bh, input logic [31:0] pc,
        input logic hit, input logic [31:0] ld, input logic sf, input logic snf);
        vec_t v;
        v.rst = rst;  v.st_v = sv;  v.st_a = sa;  v.st_d = sd;  v.st_b = sb;  v.st_p = sp;
        v.ld_v = lv;  v.ld_a = la;  v.drn = drn;
        v.e_rdy = rdy;  v.e_empty = emp;  v.e_we = we;
        v.e_addr = a;  v.e_wd = wd;  v.e_bh = bh;  v.e_pc = pc;
        v.e_hit = hit;  v.e_ld = ld;  v.e_stall_fwd = sf;  v.e_stall_nf = snf;
        return v;
    endfunction

    task automatic chk(input string grp, input int idx, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s[%0d] %s: got 0x%08h, expected 0x%08h", grp, idx, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string grp, input int idx);
        @(negedge clk);
        reset    = v.rst;
        st_valid = v.st_v;
        st_addr  = v.st_a;
        st_data  = v.st_d;
        st_byte  = v.st_b;
        st_pc    = v.st_p;
        ld_valid = v.ld_v;
        ld_addr  = v.ld_a;
        drain_en = v.drn;
        #1;
        nvec++;
        chk(grp, idx, "st_ready", 32'(st_ready), 32'(v.e_rdy));
        chk(grp, idx, "empty",    32'(empty),    32'(v.e_empty));
        chk(grp, idx, "dm_we",    32'(dm_we),    32'(v.e_we));
        if (v.e_we) begin
            chk(grp, idx, "dm_addr", dm_addr,      v.e_addr);
            chk(grp, idx, "dm_wd",   dm_wd,        v.e_wd);
            chk(grp, idx, "dm_bh",   32'(dm_bh),   32'(v.e_bh));
            chk(grp, idx, "dm_pc",   dm_pc,        v.e_pc);
        end
`ifdef STORE_BUFFER_FWD_EN
        chk(grp, idx, "ld_hit",   32'(ld_hit),   32'(v.e_hit));
        chk(grp, idx, "ld_data",  ld_data,       v.e_ld);
        chk(grp, idx, "ld_stall", 32'(ld_stall), 32'(v.e_stall_fwd));
`else
        chk(grp, idx, "ld_hit",   32'(ld_hit),   32'd0);
        chk(grp, idx, "ld_data",  ld_data,       32'd0);
        chk(grp, idx, "ld_stall", 32'(ld_stall), 32'(v.e_stall_nf));
`endif
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] wp;
        logic [31:0] pa;
        logic [31:0] pd;
        logic [31:0] pp;
        logic        live;

        reset = 1'b1;  st_valid = 1'b0;  st_addr = '0;  st_data = '0;  st_byte = 1'b0;
        st_pc = '0;  ld_valid = 1'b0;  ld_addr = '0;  drain_en = 1'b0;
        repeat (2) @(posedge clk);

        //            rst sv  st_a    st_d           sb  st_pc   lv  ld_a   drn  rdy emp we  addr   wd             bh  pc       hit ld             sF  sNF
        // reset state; draining and loading an empty queue does nothing
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h10, 1,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        // single store, drained the next cycle
        tbl.push_back(mk(0, 1, 32'h10, 32'h12345678,  0, 32'h3000, 0, 32'h0,  1,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h10, 1,   1,  0,  1, 32'h10, 32'h12345678,  0, 32'h3000, 1, 32'h12345678,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,  1,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        // fill with drain held off
        tbl.push_back(mk(0, 1, 32'h40, 32'hA0,        0, 32'h100,  0, 32'h0,  0,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h44, 32'hA1,        0, 32'h104,  0, 32'h0,  0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h48, 32'hA2,        0, 32'h108,  0, 32'h0,  0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h4C, 32'hA3,        0, 32'h10C,  0, 32'h0,  0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        // full: 5th store dropped; store during a popping cycle also dropped
        tbl.push_back(mk(0, 1, 32'h50, 32'hDEAD,      0, 32'h110,  0, 32'h0,  0,   0,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h60, 32'hBEEF,      0, 32'h114,  0, 32'h0,  1,   0,  0,  1, 32'h40, 32'hA0,        0, 32'h100,  0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,  1,   1,  0,  1, 32'h44, 32'hA1,        0, 32'h104,  0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,  1,   1,  0,  1, 32'h48, 32'hA2,        0, 32'h108,  0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,  1,   1,  0,  1, 32'h4C, 32'hA3,        0, 32'h10C,  0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,  1,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        // forwarding: youngest word wins; same-cycle store invisible
        tbl.push_back(mk(0, 1, 32'h20, 32'hAAAA0001,  0, 32'h200,  0, 32'h0,  0,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h20, 32'hBBBB0002,  0, 32'h204,  1, 32'h22, 0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    1, 32'hAAAA0001,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h22, 0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    1, 32'hBBBB0002,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h22, 0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h24, 0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h22, 1,   1,  0,  1, 32'h20, 32'hAAAA0001,  0, 32'h200,  1, 32'hBBBB0002,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h20, 1,   1,  0,  1, 32'h20, 32'hBBBB0002,  0, 32'h204,  1, 32'hBBBB0002,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h20, 0,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        // byte conflict: stall until the sb entry has popped
        tbl.push_back(mk(0, 1, 32'h30, 32'h11111111,  0, 32'h300,  0, 32'h0,  0,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h31, 32'h22,        1, 32'h304,  0, 32'h0,  0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h30, 0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         1,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h30, 1,   1,  0,  1, 32'h30, 32'h11111111,  0, 32'h300,  0, 32'h0,         1,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h30, 1,   1,  0,  1, 32'h31, 32'h22,        1, 32'h304,  0, 32'h0,         1,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h30, 0,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        // older sb, younger sw to the same word: the word store wins
        tbl.push_back(mk(0, 1, 32'h34, 32'h55,        1, 32'h308,  0, 32'h0,  0,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));
        tbl.push_back(mk(0, 1, 32'h34, 32'h66666666,  0, 32'h30C,  1, 32'h37, 0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         1,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h37, 0,   1,  0,  0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h66666666,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h37, 1,   1,  0,  1, 32'h34, 32'h55,        1, 32'h308,  1, 32'h66666666,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    1, 32'h37, 1,   1,  0,  1, 32'h34, 32'h66666666,  0, 32'h30C,  1, 32'h66666666,  0,  1));
        tbl.push_back(mk(0, 0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,  1,   1,  1,  0, 32'h0,  32'h0,         0, 32'h0,    0, 32'h0,         0,  0));

        foreach (tbl[i]) apply(tbl[i], "tbl", i);

        // Wrap: head/tail now sit at slot 3. Push item j in cycle j and pop
        // item j-1 in the same cycle, so the queue holds exactly one entry
        // through cycles 1..11; the load probes that entry (byte offset 1).
        for (int j = 0; j <= 12; j++) begin
            wa = 32'h1000 + 32'(4 * j);
            wd = 32'hC0DE0000 + 32'(j);
            wp = 32'h4000 + 32'(4 * j);
            pa = 32'h1000 + 32'(4 * (j - 1));
            pd = 32'hC0DE0000 + 32'(j - 1);
            pp = 32'h4000 + 32'(4 * (j - 1));
            live = (j >= 1) && (j <= 11);
            v = mk(0, j <= 10, wa, wd, 0, wp, j >= 1, pa + 32'h1, 1,
                   1, !live, live, pa, pd, 0, pp, live, live ? pd : 32'h0, 0, live);
            apply(v, "wrap", j);
        end

        // Reset with three stores pending and drain enabled: no write on the
        // reset edge, queue empty afterwards, and a fresh store drains normally.
        apply(mk(0, 1, 32'h700, 32'h70, 0, 32'h500, 0, 32'h0,   0, 1, 1, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0, 0, 0), "rst", 0);
        apply(mk(0, 1, 32'h704, 32'h71, 0, 32'h504, 0, 32'h0,   0, 1, 0, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0, 0, 0), "rst", 1);
        apply(mk(0, 1, 32'h708, 32'h72, 0, 32'h508, 0, 32'h0,   0, 1, 0, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0, 0, 0), "rst", 2);
        apply(mk(1, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 0, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0, 0, 0), "rst", 3);
        apply(mk(0, 0, 32'h0,   32'h0,  0, 32'h0,   1, 32'h700, 1, 1, 1, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0, 0, 0), "rst", 4);
        apply(mk(0, 1, 32'h800, 32'h80, 0, 32'h600, 0, 32'h0,   1, 1, 1, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0, 0, 0), "rst", 5);
        apply(mk(0, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 0, 1, 32'h800, 32'h80, 0, 32'h600, 0, 32'h0, 0, 0), "rst", 6);
        apply(mk(0, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0,   1, 1, 1, 0, 32'h0,   32'h0,  0, 32'h0,   0, 32'h0, 0, 0), "rst", 7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store queue between the MEM-stage pipeline register and the data memory. Stores retire from the pipeline into a small FIFO and drain to the data memory one per cycle, so a store never stalls the pipeline unless the queue is full. Loads in MEM are checked against pending entries. A full-word hit is forwarded; a partially covering (byte) hit requests a stall until that entry has drained.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears the queue
- st_valid  in  1  MEM stage presents a store this cycle
- st_ready  out  1  queue can accept; equals (count < DEPTH)
- st_addr  in  32  byte address of the store
- st_data  in  32  store data, unshifted (byte stores use [7:0])
- st_byte  in  1  1 = byte store (sb), 0 = word store (sw)
- st_pc  in  32  PC of the store instruction, carried for write logging
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_addr  in  32  byte address of the load
- ld_hit  out  1  forward ld_data instead of the memory read
- ld_data  out  32  full word from the youngest matching word store
- ld_stall  out  1  load must wait; the matching entry is not forwardable
- drain_en  in  1  permits writing the head entry to memory this cycle
- dm_we  out  1  memory write enable; pop happens on the same edge
- dm_addr  out  32  head address (to memory A)
- dm_wd  out  32  head data (to memory WD)
- dm_bh  out  1  head st_byte (to memory BH)
- dm_pc  out  32  head PC (to memory pc)
- empty  out  1  count == 0; used to fence syscall/eret

## Operation
- Storage: DEPTH entries of {addr, data, byte, pc}. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Push: st_valid && st_ready at a rising edge writes the entry at tail, then tail+1.
- Pop: dm_we at a rising edge, then head+1.
- Push and pop in the same cycle: count is unchanged. A full queue does not accept a push, even in a cycle where it pops.
- Drain outputs: dm_we = !empty && drain_en. dm_addr, dm_wd, dm_bh and dm_pc come directly from the head entry. When empty, the data outputs hold the stale head.
- Load match: an entry matches when it is valid and entry.addr[31:2] == ld_addr[31:2]. Only the youngest matching entry counts, found by scanning from tail-1 back toward head.
  - Youngest match is a word store: ld_hit=1, ld_data=entry.data, ld_stall=0.
  - Youngest match is a byte store: ld_hit=0, ld_stall=1.
  - No match, or ld_valid=0: ld_hit=0 and ld_stall=0.
- The head entry being popped in the same cycle still matches. The memory write lands on that edge, so stalling one extra cycle is correct.
- A store presented in the same cycle as the load is not visible to that load. The pipeline orders it.

## Timing
- Reset values: st_ready=1, empty=1, dm_we=0, ld_hit=0, ld_stall=0, and ld_data=0 whenever ld_hit=0. Head, tail and count are 0; entry contents are don't-care.
- Reset mid-drain: pending stores are discarded, with no memory write on the reset edge.
- Latency:
  - A store accepted at edge N is at head by N+1 if the queue was empty. It writes memory at edge N+1 if drain_en is high.
  - Throughput is one push and one pop per cycle.
- All outputs are combinational from registered state plus ld_addr and drain_en. There is no combinational path from st_* to any output.
- Wrap-around: pointers roll from DEPTH-1 to 0. The forwarding scan is correct across the wrap.

## Configuration
- STORE_BUFFER_FWD_EN defined: forwarding as above.
- STORE_BUFFER_FWD_EN undefined:
  - ld_hit is tied to 0 and ld_data to 0.
  - ld_stall = ld_valid && any valid entry matches, whether word or byte.
  - The youngest-match priority logic is removed.

## Structure
- Shared package holds:
  - the entry struct {addr[31:0], data[31:0], byte, pc[31:0]}
  - the STORE_BUFFER_DEPTH default constant
  - the word-address helper (addr[31:2])
- One sub-module, sb_match: combinational youngest-match search. Inputs are the entry array, the valid mask and the tail pointer; outputs are hit_valid, hit_idx and hit_byte. It is instantiated only under STORE_BUFFER_FWD_EN.

## Test plan
- Single store, drain_en=1: sw 0x0000_0010←0x1234_5678, pc 0x0000_3000 -> dm_we=1 one cycle later with dm_addr=0x10, dm_wd=0x12345678, dm_bh=0; empty=1 after.
- Fill with drain_en=0: four sw -> st_ready=0 after the 4th; a 5th st_valid is dropped, count stays 4. Raising drain_en pops in FIFO order over 4 cycles.
- Forwarding: sw 0x20←0xAAAA_0001 then sw 0x20←0xBBBB_0002, drain_en=0, load 0x22 -> ld_hit=1, ld_data=0xBBBB0002, ld_stall=0.
- Byte conflict: sw 0x30←0x11111111, then sb 0x31←0x22, load 0x30 -> ld_stall=1 until the sb entry is popped, then ld_stall=0.
- Wrap plus simultaneous push/pop: continuous push and pop for 10 cycles with DEPTH=4 -> count constant, every entry written to memory exactly once in order, pointers wrap cleanly.
- Reset mid-operation: 3 entries pending, reset=1 for one cycle -> no dm_we on that edge; empty=1, st_ready=1 next cycle.
